// File: rtl/fan_pi_sequencer.sv
// Discrete PI controller sequencer: error/integrator update, two multiplier
// passes (Kp*e, Ki*I) over a start/done handshake, then a saturated duty output.
module fan_pi_sequencer #(
  parameter int N = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  tick_strb_i,
  input  logic [N-1:0]          setpoint_i,
  input  logic [N-1:0]          actual_i,
  input  logic signed [2*N-1:0] kp_i,
  input  logic signed [2*N-1:0] ki_i,
  output logic                  mul_start_strb_o,
  output logic signed [2*N-1:0] mul_a_o,
  output logic signed [2*N-1:0] mul_b_o,
  input  logic                  mul_done_strb_i,
  input  logic signed [2*N-1:0] mul_out_i,
  output logic [N-1:0]          duty_o,
  output logic signed [2*N-1:0] integ_o,
  output logic                  busy_o,
  output logic                  done_strb_o
);

  localparam int W = 2 * N;
  localparam logic signed [W:0] I_MAX = (W+1)'((1 << (W-1)) - 1);
  localparam logic signed [W:0] I_MIN = ~I_MAX;
  localparam logic signed [W:0] D_MAX = (W+1)'((1 << N) - 1);

  typedef enum logic [2:0] {
    IDLE, ERR, P_START, P_WAIT, I_START, I_WAIT, SUM
  } state_t;

  state_t state_q, state_d;
  logic signed [W-1:0] err_q, err_d;
  logic signed [W-1:0] integ_q, integ_d;
  logic signed [W-1:0] a_q, a_d;
  logic signed [W-1:0] b_q, b_d;
  logic signed [W-1:0] p_q, p_d;
  logic signed [W-1:0] ii_q, ii_d;
  logic [N-1:0]        duty_q, duty_d;
  logic                done_q, done_d;

  logic signed [W-1:0] err_c;
  logic signed [W:0]   isum_c;
  logic signed [W:0]   usum_c;

  // Zero-extended unsigned inputs make the difference exact in W bits.
  assign err_c  = $signed({{N{1'b0}}, setpoint_i}) - $signed({{N{1'b0}}, actual_i});
  assign isum_c = {integ_q[W-1], integ_q} + {err_c[W-1], err_c};
  assign usum_c = {p_q[W-1], p_q} + {ii_q[W-1], ii_q};

  always_comb begin
    state_d          = state_q;
    err_d            = err_q;
    integ_d          = integ_q;
    a_d              = a_q;
    b_d              = b_q;
    p_d              = p_q;
    ii_d             = ii_q;
    duty_d           = duty_q;
    done_d           = 1'b0;
    mul_start_strb_o = 1'b0;
    mul_a_o          = a_q;
    mul_b_o          = b_q;
    case (state_q)
      IDLE: begin
        if (tick_strb_i) state_d = ERR;
      end
      ERR: begin
        err_d = err_c;
        if (isum_c > I_MAX)      integ_d = I_MAX[W-1:0];
        else if (isum_c < I_MIN) integ_d = I_MIN[W-1:0];
        else                     integ_d = isum_c[W-1:0];
        state_d = P_START;
      end
      P_START: begin
        // Gain is taken live in the start cycle, then held in a_q while waiting.
        a_d              = kp_i;
        b_d              = err_q;
        mul_a_o          = kp_i;
        mul_b_o          = err_q;
        mul_start_strb_o = 1'b1;
        state_d          = P_WAIT;
      end
      P_WAIT: begin
        if (mul_done_strb_i) begin
          p_d     = mul_out_i;
          state_d = I_START;
        end
      end
      I_START: begin
        a_d              = ki_i;
        b_d              = integ_q;
        mul_a_o          = ki_i;
        mul_b_o          = integ_q;
        mul_start_strb_o = 1'b1;
        state_d          = I_WAIT;
      end
      I_WAIT: begin
        if (mul_done_strb_i) begin
          ii_d    = mul_out_i;
          state_d = SUM;
        end
      end
      SUM: begin
        if (usum_c[W])           duty_d = '0;
        else if (usum_c > D_MAX) duty_d = '1;
        else                     duty_d = usum_c[N-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      err_q   <= '0;
      integ_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      ii_q    <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      integ_q <= integ_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      ii_q    <= ii_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  // busy drops on the same edge that publishes duty and raises done.
  assign busy_o      = (state_q != IDLE);
  assign done_strb_o = done_q;
  assign duty_o      = duty_q;
  assign integ_o     = integ_q;

endmodule
